n_bit_counter: RTL and testbench

N_BIT_COUNTER -- requirements
Module: n_bit_counter

---
 rtl/n_bit_counter.sv | 38 +++
 tb/tb_n_bit_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/n_bit_counter.sv
// n_bit_counter: loadable, enabled, wrap-around up counter.
//
// Ports:
//   clk        - single clock, rising-edge active
//   rst        - asynchronous reset, active-low; forces count to RESET_VALUE
//   ld         - synchronous load enable (highest priority)
//   en         - synchronous count enable
//   start_seq  - value loaded into the counter when ld is high
//   count      - current counter value, registered output
//
// Parameters:
//   WIDTH        - counter and load-data width in bits (>= 1)
//   RESET_VALUE  - value held by count while rst is low
module n_bit_counter #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] start_seq,
    output logic [WIDTH-1:0] count
);

    // Counter register: load beats increment, increment beats hold.
    // The increment wraps naturally modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VALUE;
        end else if (ld) begin
            count <= start_seq;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_n_bit_counter.sv
// Directed self-checking bench for n_bit_counter (WIDTH=8, RESET_VALUE=0).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_n_bit_counter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             ld;
    logic             en;
    logic [WIDTH-1:0] start_seq;
    logic [WIDTH-1:0] count;

    int unsigned n_checks;
    int unsigned n_pass;

    n_bit_counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .en       (en),
        .start_seq(start_seq),
        .count    (count)
    );

    // 50 ns clock period
    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        ld        = 1'b0;
        en        = 1'b1;
        start_seq = 8'h00;

        // Reset held for 5 cycles with en=1: count stays 0
        #1;
        check_eq("reset_initial", count, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("reset_hold_%0d", i), count, 8'h00);
        end

        // Release reset, one idle cycle, then 10 counting edges
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check_eq("idle_after_reset", count, 8'h00);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("count_step_%0d", i), count, 8'(i + 1));
        end

        // Mid-cycle reset from a nonzero count (0x0A)
        #5;
        rst = 1'b0;
        #5;
        check_eq("midcycle_reset", count, 8'h00);
        tick();
        check_eq("midcycle_reset_held", count, 8'h00);
        rst = 1'b1;

        // Load has priority over enable
        start_seq = 8'h5A;
        ld        = 1'b1;
        en        = 1'b1;
        tick();
        check_eq("load_priority", count, 8'h5A);
        ld = 1'b0;
        tick();
        check_eq("load_then_inc", count, 8'h5B);

        // Wrap-around from 0xFE
        start_seq = 8'hFE;
        ld        = 1'b1;
        en        = 1'b0;
        tick();
        check_eq("load_fe", count, 8'hFE);
        ld = 1'b0;
        en = 1'b1;
        tick();
        check_eq("wrap_ff", count, 8'hFF);
        tick();
        check_eq("wrap_00", count, 8'h00);
        tick();
        check_eq("wrap_01", count, 8'h01);

        // Load all-ones then increment on the very next edge
        start_seq = 8'hFF;
        ld        = 1'b1;
        tick();
        check_eq("load_ff", count, 8'hFF);
        ld = 1'b0;
        tick();
        check_eq("ff_inc_to_00", count, 8'h00);

        // Hold at 0x33 for 4 edges
        start_seq = 8'h33;
        ld        = 1'b1;
        en        = 1'b0;
        tick();
        check_eq("load_33", count, 8'h33);
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("hold_%0d", i), count, 8'h33);
        end

        // Async reset between edges at 0x40, ld/en ignored while low
        start_seq = 8'h40;
        ld        = 1'b1;
        tick();
        check_eq("load_40", count, 8'h40);
        ld = 1'b0;
        en = 1'b1;
        #10;
        rst = 1'b0;
        #1;
        check_eq("async_reset_immediate", count, 8'h00);
        ld        = 1'b1;
        start_seq = 8'h77;
        tick();
        check_eq("reset_ignores_ld_en", count, 8'h00);
        ld  = 1'b0;
        #10;
        rst = 1'b1;
        tick();
        check_eq("first_edge_after_reset", count, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
